// File: rtl/sine_table_sequencer_if.sv
// rtl/sine_table_sequencer_if.sv - control, table and sample-stream bundle for the sine sequencer
interface sine_table_sequencer_if #(
    parameter int SINE_SIZE = 8,
    parameter int IDX_W     = 6,
    parameter int DIV_W     = 16
);
    logic                 start;
    logic                 stop;
    logic                 continuous;
    logic [DIV_W-1:0]     div;
    logic [IDX_W-1:0]     table_last;
    logic [SINE_SIZE-1:0] table_data;
    logic [IDX_W-1:0]     table_addr;
    logic [SINE_SIZE-1:0] sample_out;
    logic                 sample_valid;
    logic                 period_done;
    logic                 busy;

    // Controller / table / consumer side
    modport master (
        output start, stop, continuous, div, table_last, table_data,
        input  table_addr, sample_out, sample_valid, period_done, busy
    );

    // Sequencer side
    modport slave (
        input  start, stop, continuous, div, table_last, table_data,
        output table_addr, sample_out, sample_valid, period_done, busy
    );
endinterface

// File: rtl/sine_table_sequencer.sv
// rtl/sine_table_sequencer.sv - walks a half-sine table up and down into full raised-sine periods
module sine_table_sequencer #(
    parameter int SINE_SIZE  = 8,
    parameter int TABLE_SIZE = 32,
    parameter int IDX_W      = 6,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sine_table_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2
    } state_t;

    // Highest index that physically exists in the table; a larger table_last is clamped here.
    localparam logic [IDX_W-1:0] MAX_LAST = IDX_W'(TABLE_SIZE - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     addr_q, addr_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [SINE_SIZE-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [DIV_W-1:0]     div_l_q, div_l_d;
    logic                 cont_l_q, cont_l_d;
    logic [IDX_W-1:0]     last_l_q, last_l_d;

    logic                 period_end;
    logic                 stop_now;

    // Next-state logic: start acceptance, sample-rate tick and the up/down table walk
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        div_l_d     = div_l_q;
        cont_l_d    = cont_l_q;
        last_l_d    = last_l_q;
        period_end  = 1'b0;
        stop_now    = stop_pend_q | bus.stop;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.table_last != '0)) begin
                    state_d     = S_RISE;
                    addr_d      = '0;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                    div_l_d     = bus.div;
                    cont_l_d    = bus.continuous;
                    last_l_d    = (bus.table_last > MAX_LAST) ? MAX_LAST : bus.table_last;
                end
            end
            default: begin
                stop_pend_d = stop_now;
                if (cnt_q == div_l_q) begin
                    cnt_d    = '0;
                    sample_d = bus.table_data;
                    valid_d  = 1'b1;
                    if (state_q == S_RISE) begin
                        if (addr_q < last_l_q) begin
                            addr_d = addr_q + IDX_W'(1);
                        end else if (last_l_q == IDX_W'(1)) begin
                            // With a two-entry table the falling half is empty: the peak closes the period.
                            period_end = 1'b1;
                        end else begin
                            state_d = S_FALL;
                            addr_d  = last_l_q - IDX_W'(1);
                        end
                    end else begin
                        if (addr_q > IDX_W'(1)) begin
                            addr_d = addr_q - IDX_W'(1);
                        end else begin
                            period_end = 1'b1;
                        end
                    end
                    if (period_end) begin
                        done_d = 1'b1;
                        addr_d = '0;
                        if (cont_l_q && !stop_now) begin
                            state_d = S_RISE;
                        end else begin
                            state_d     = S_IDLE;
                            stop_pend_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            div_l_q     <= '0;
            cont_l_q    <= 1'b0;
            last_l_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            div_l_q     <= div_l_d;
            cont_l_q    <= cont_l_d;
            last_l_q    <= last_l_d;
        end
    end

    assign bus.table_addr   = addr_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.period_done  = done_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_sine_table_sequencer.sv
// tb/tb_sine_table_sequencer.sv - self-checking bench for sine_table_sequencer
module tb_sine_table_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sine_table_sequencer_if #(.SINE_SIZE(8), .IDX_W(6), .DIV_W(16)) bus ();

    sine_table_sequencer #(
        .SINE_SIZE(8), .TABLE_SIZE(32), .IDX_W(6), .DIV_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] tbl [64];
    assign bus.table_data = tbl[bus.table_addr];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        bit cont;
        int L;
        int stop_at;
        int restart_at;
        int chg_at;
        int rst_at;
        int exp_n;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Table index of the n-th sample (1-based) of a run: 0..L then L-1..1, repeating
    function automatic int exp_idx(input int n, input int L);
        int p;
        p = (n - 1) % (2 * L);
        return (p <= L) ? p : 2 * L - p;
    endfunction

    // Sample count of a run: one period, or up to the first period end after stop is seen
    function automatic int model_total(input bit cont, input int L, input int stop_at);
        if (!cont) return 2 * L;
        return (stop_at / (2 * L) + 1) * 2 * L;
    endfunction

    task automatic run(input int d, input bit cont, input int L, input int stop_at,
                       input int restart_at, input int chg_at, input int rst_at,
                       input int exp_n, input string tag);
        int n;
        int lim;
        int last_val;
        bit v;
        @(negedge clk);
        bus.div        = 16'(d);
        bus.continuous = cont;
        bus.table_last = 6'(L);
        bus.stop       = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, " busy_after_start"}, int'(bus.busy), 1);
        n = 0;
        last_val = -1;
        lim = (exp_n + 1) * (d + 1) + 4;
        for (int c = 1; c <= lim && n < exp_n; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            v = ((c % (d + 1)) == 0);
            chk({tag, " valid"}, int'(bus.sample_valid), int'(v));
            chk({tag, " addr_range"}, int'(bus.table_addr <= 6'(L)), 1);
            if (v) begin
                n++;
                last_val = int'(tbl[exp_idx(n, L)]);
                chk($sformatf("%s sample%0d", tag, n), int'(bus.sample_out), last_val);
                chk($sformatf("%s done%0d", tag, n), int'(bus.period_done),
                    int'((n % (2 * L)) == 0));
                chk($sformatf("%s busy%0d", tag, n), int'(bus.busy),
                    int'((n < exp_n) || (rst_at > 0)));
                if (n == stop_at) bus.stop = 1'b1;
                if (n == restart_at) begin
                    bus.start      = 1'b1;
                    bus.div        = 16'(d + 7);
                    bus.continuous = !cont;
                end
                if (n == chg_at) begin
                    bus.div        = 16'd5;
                    bus.table_last = 6'd3;
                end
            end else begin
                chk({tag, " done_idle"}, int'(bus.period_done), 0);
                chk({tag, " busy_mid"}, int'(bus.busy), 1);
            end
        end
        chk({tag, " sample_count"}, n, exp_n);
        if (rst_at > 0) begin
            rst_n = 1'b0;
            #1;
            chk({tag, " rst_sample"}, int'(bus.sample_out), 0);
            chk({tag, " rst_valid"}, int'(bus.sample_valid), 0);
            chk({tag, " rst_done"}, int'(bus.period_done), 0);
            chk({tag, " rst_busy"}, int'(bus.busy), 0);
            chk({tag, " rst_addr"}, int'(bus.table_addr), 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        repeat (d + 3) begin
            @(posedge clk); #1;
            chk({tag, " post_valid"}, int'(bus.sample_valid), 0);
            chk({tag, " post_busy"}, int'(bus.busy), 0);
            if (last_val >= 0) chk({tag, " post_hold"}, int'(bus.sample_out), last_val);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 1'b0, 31, 0,   0,  0, 0,  62};
        vecs[1]  = '{3, 1'b0, 31, 0,   0,  0, 0,  62};
        vecs[2]  = '{0, 1'b1, 31, 130, 0,  0, 0,  186};
        vecs[3]  = '{0, 1'b1, 31, 10,  20, 0, 0,  62};
        vecs[4]  = '{0, 1'b1, 31, 62,  0,  0, 0,  124};
        vecs[5]  = '{0, 1'b1, 31, 61,  0,  0, 0,  62};
        vecs[6]  = '{0, 1'b0, 31, 0,   0,  0, 40, 40};
        vecs[7]  = '{0, 1'b0, 31, 0,   0,  0, 0,  62};
        vecs[8]  = '{0, 1'b0, 31, 0,   0,  5, 0,  62};
        vecs[9]  = '{2, 1'b0, 1,  0,   0,  0, 0,  2};
        vecs[10] = '{1, 1'b1, 2,  4,   0,  0, 0,  8};

        for (int i = 0; i < 64; i++) begin
            if (i < 32) tbl[i] = 8'($rtoi(127.0 * (1.0 - $cos(3.14159265358979 * i / 31.0)) + 0.5));
            else        tbl[i] = 8'($urandom);
        end

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.div        = '0;
        bus.table_last = 6'd31;
        #1;
        chk("reset_sample", int'(bus.sample_out), 0);
        chk("reset_valid", int'(bus.sample_valid), 0);
        chk("reset_done", int'(bus.period_done), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_addr", int'(bus.table_addr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stop while idle is ignored
        @(negedge clk);
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        chk("idle_stop_busy", int'(bus.busy), 0);

        // Start with an empty table is ignored
        @(negedge clk);
        bus.table_last = 6'd0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) begin
            chk("last0_busy", int'(bus.busy), 0);
            chk("last0_valid", int'(bus.sample_valid), 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 11; i++) begin
            run(vecs[i].d, vecs[i].cont, vecs[i].L, vecs[i].stop_at, vecs[i].restart_at,
                vecs[i].chg_at, vecs[i].rst_at, vecs[i].exp_n, $sformatf("v%0d", i));
        end

        for (int r = 0; r < 6; r++) begin
            int d;
            int L;
            bit cont;
            int sa;
            for (int i = 0; i < 64; i++) tbl[i] = 8'($urandom);
            d    = $urandom_range(0, 3);
            L    = $urandom_range(1, 20);
            cont = 1'($urandom_range(0, 1));
            sa   = cont ? $urandom_range(1, 6 * L) : 0;
            run(d, cont, L, sa, 0, 0, 0, model_total(cont, L, sa), $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
